// File: rtl/mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl
//
// Request-queuing controller placed directly in front of a single-port memory.
// Read/write requests arrive over a valid/ready handshake and are buffered in a
// small circular FIFO. An FSM issues them to the memory one at a time, in
// acceptance order. Read data is returned over a second valid/ready handshake.
// A read of an address at or beyond LOCATIONS returns an error response with
// zero data. A write to such an address is silently dropped.
//
// Memory contract driven by this block:
//   mem_op = 1 : write, committed at the clock edge where mem_op is high.
//   mem_op = 0 : read; mem_data_out is registered and valid in the cycle
//                after the address is presented.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   req_valid    in   request present
//   req_ready    out  FIFO can accept a request
//   req_op       in   1 = write, 0 = read
//   req_addr     in   [AW]       target address
//   req_data     in   [LOC_SIZE] write data (ignored for reads)
//   rsp_valid    out  read response present
//   rsp_ready    in   consumer accepts the response
//   rsp_data     out  [LOC_SIZE] read data (0 on error)
//   rsp_err      out  read address was out of range
//   mem_reset    out  reset forwarded unchanged to the memory
//   mem_op       out  memory operation (1 = write)
//   mem_addr     out  [AW]       memory address
//   mem_data_in  out  [LOC_SIZE] memory write data
//   mem_data_out in   [LOC_SIZE] memory read data
//   busy         out  FIFO non-empty or FSM not idle
// -----------------------------------------------------------------------------
module mem_req_ctrl #(
    parameter  int LOCATIONS = 16,
    parameter  int LOC_SIZE  = 8,
    parameter  int DEPTH     = 4,
    localparam int AW        = $clog2(LOCATIONS)
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [AW-1:0]       req_addr,
    input  logic [LOC_SIZE-1:0] req_data,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [LOC_SIZE-1:0] rsp_data,
    output logic                rsp_err,

    output logic                mem_reset,
    output logic                mem_op,
    output logic [AW-1:0]       mem_addr,
    output logic [LOC_SIZE-1:0] mem_data_in,
    input  logic [LOC_SIZE-1:0] mem_data_out,

    output logic                busy
);

    // -------------------------------------------------------------------------
    // Local parameters
    // -------------------------------------------------------------------------
    localparam int PW = $clog2(DEPTH);      // FIFO pointer width
    localparam int CW = $clog2(DEPTH + 1);  // FIFO occupancy width

    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    // One extra bit so that LOCATIONS == 2**AW is representable.
    localparam logic [AW:0]   LOC_LIMIT = (AW + 1)'(LOCATIONS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    // -------------------------------------------------------------------------
    // FIFO state
    // -------------------------------------------------------------------------
    logic                fifo_op_q   [DEPTH];
    logic [AW-1:0]       fifo_addr_q [DEPTH];
    logic [LOC_SIZE-1:0] fifo_data_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    logic                head_op;
    logic [AW-1:0]       head_addr;
    logic [LOC_SIZE-1:0] head_data;
    logic                head_in_range;

    // -------------------------------------------------------------------------
    // FSM / datapath state
    // -------------------------------------------------------------------------
    logic [2:0]          state_q,    state_d;
    logic [AW-1:0]       cur_addr_q, cur_addr_d;
    logic [LOC_SIZE-1:0] cur_data_q, cur_data_d;
    logic [LOC_SIZE-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_err_q,  rsp_err_d;

    // -------------------------------------------------------------------------
    // FIFO control
    // -------------------------------------------------------------------------
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);

    // Ready depends only on registered occupancy: a pop in the same cycle does
    // not open a slot until the following cycle.
    assign req_ready  = !fifo_full && !reset;
    assign push       = req_valid && req_ready;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;

    assign head_op       = fifo_op_q[rd_ptr_q];
    assign head_addr     = fifo_addr_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];
    assign head_in_range = ({1'b0, head_addr} < LOC_LIMIT);

    always_comb begin
        // NOTE: every variable assigned in an always_comb block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the FIFO storage has no reset; an entry is only read after it was
    // written, and occupancy/pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_q[wr_ptr_q]   <= req_op;
            fifo_addr_q[wr_ptr_q] <= req_addr;
            fifo_data_q[wr_ptr_q] <= req_data;
        end
    end

    // -------------------------------------------------------------------------
    // Issue FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        cur_data_d = cur_data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_in_range) begin
                        // cur_addr only follows in-range requests, so the
                        // memory never sees an out-of-range address.
                        cur_addr_d = head_addr;
                        cur_data_d = head_data;
                        state_d    = head_op ? S_WRITE : S_READ;
                    end else if (!head_op) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end
                    // Out-of-range write: popped and dropped, stay idle.
                end
            end

            S_WRITE: begin
                state_d = S_IDLE;
            end

            S_READ: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Memory output is valid in this cycle, one after the address.
                rsp_data_d = mem_data_out;
                rsp_err_d  = 1'b0;
                state_d    = S_RESP;
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            cur_data_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            cur_data_q <= cur_data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // mem_op is decoded from the asynchronously reset state register, so a
    // reset during WRITE drops it at once and the pending commit never occurs.
    assign mem_op      = (state_q == S_WRITE);
    assign mem_addr    = cur_addr_q;
    assign mem_data_in = mem_op ? cur_data_q : '0;
    assign mem_reset   = reset;

    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;

    assign busy        = !fifo_empty || (state_q != S_IDLE);

endmodule
